// File: rtl/pipo_register.sv
// Parallel-in/parallel-out holding register with load enable and
// asynchronous active-high reset to a parameterised value.
module pipo_register #(
  parameter int unsigned            WIDTH       = 4,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pout <= RESET_VALUE;
    end else if (load) begin
      pout <= pin;
    end
  end

endmodule

// File: tb/tb_pipo_register.sv
// Directed bench for pipo_register: default 4-bit instance plus WIDTH=1 and
// WIDTH=32 instances with an all-ones reset value, driven in lockstep.
module tb_pipo_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  pin4 = '0;
  logic [0:0]  pin1 = '0;
  logic [31:0] pin32 = '0;
  logic [3:0]  pout4;
  logic [0:0]  pout1;
  logic [31:0] pout32;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  pipo_register dut4 (
    .clk(clk), .rst(rst), .load(load), .pin(pin4), .pout(pout4)
  );

  pipo_register #(.WIDTH(1), .RESET_VALUE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .pin(pin1), .pout(pout1)
  );

  pipo_register #(.WIDTH(32), .RESET_VALUE(32'hFFFF_FFFF)) dut32 (
    .clk(clk), .rst(rst), .load(load), .pin(pin32), .pout(pout32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e4,
                           input logic [0:0] e1, input logic [31:0] e32);
    check({tag, "/w4"},  {60'd0, pout4},  {60'd0, e4});
    check({tag, "/w1"},  {63'd0, pout1},  {63'd0, e1});
    check({tag, "/w32"}, {32'd0, pout32}, {32'd0, e32});
  endtask

  task automatic drive(input logic ld, input logic [3:0] p4,
                       input logic [0:0] p1, input logic [31:0] p32);
    @(negedge clk);
    load  = ld;
    pin4  = p4;
    pin1  = p1;
    pin32 = p32;
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset applied before any clock edge must act immediately.
    #1;
    rst = 1'b1; load = 1'b1; pin4 = 4'b1111; pin1 = 1'b0; pin32 = 32'h1234_5678;
    #1;
    check_all("reset_async", 4'b0000, 1'b1, 32'hFFFF_FFFF);

    edge_then_sample();
    check_all("reset_overrides_load", 4'b0000, 1'b1, 32'hFFFF_FFFF);

    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;

    // Single load pulse; pout must not follow pin before the edge.
    drive(1'b1, 4'b1010, 1'b0, 32'hA5A5_0F0F);
    #1;
    check_all("no_comb_path", 4'b0000, 1'b1, 32'hFFFF_FFFF);
    edge_then_sample();
    check_all("load_pulse", 4'b1010, 1'b0, 32'hA5A5_0F0F);

    // Hold for two edges while pin changes.
    drive(1'b0, 4'b1100, 1'b1, 32'h0000_FFFF);
    edge_then_sample();
    check_all("hold_1", 4'b1010, 1'b0, 32'hA5A5_0F0F);
    edge_then_sample();
    check_all("hold_2", 4'b1010, 1'b0, 32'hA5A5_0F0F);

    // Sustained load tracks pin at every edge.
    drive(1'b1, 4'b1100, 1'b1, 32'h0000_FFFF);
    edge_then_sample();
    check_all("sustain_1", 4'b1100, 1'b1, 32'h0000_FFFF);
    drive(1'b1, 4'b0011, 1'b0, 32'hDEAD_BEEF);
    edge_then_sample();
    check_all("sustain_2", 4'b0011, 1'b0, 32'hDEAD_BEEF);

    // Mid-operation reset pulse between edges.
    drive(1'b0, 4'b0110, 1'b1, 32'h8000_0001);
    rst = 1'b1;
    #1;
    check_all("mid_reset", 4'b0000, 1'b1, 32'hFFFF_FFFF);
    #1;
    rst = 1'b0;
    edge_then_sample();
    check_all("post_reset_hold_1", 4'b0000, 1'b1, 32'hFFFF_FFFF);
    edge_then_sample();
    check_all("post_reset_hold_2", 4'b0000, 1'b1, 32'hFFFF_FFFF);

    // Load again after reset release.
    drive(1'b1, 4'b0101, 1'b0, 32'h0F0F_A5A5);
    edge_then_sample();
    check_all("reload", 4'b0101, 1'b0, 32'h0F0F_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
